mem_arbiter: RTL and testbench

Single-port memory arbiter for the RISC-V core. It shares the one word-wide data memory between the instruction-fetch port and the load/store port. It resolves contention with data-priority plus a fetch anti-starvation counter. It implements byte/halfword stores as a two-cycle read-modify-write, because the memory has no byte enables. It sits between the core's IF/MEM stages and the memory instance.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store.
// Data has priority; a starvation counter eventually hands the port to fetch.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int FETCH_MAX  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [31:0]             d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int          LANES      = DATA_WIDTH / 8;
    localparam logic [3:0]  STARVE_MAX = 4'(FETCH_MAX);
    localparam logic [LANES-1:0] BE_ALL = '1;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              starve_cnt_reg, starve_cnt_next;
    logic [ADDR_WIDTH-1:0]   rmw_addr_reg;
    logic [DATA_WIDTH-1:0]   rmw_data_reg;
    logic                    if_rvalid_reg, d_rvalid_reg;
    logic [DATA_WIDTH-1:0]   if_rdata_reg, d_rdata_reg;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic                    rmw_load;
    logic [ADDR_WIDTH-1:0]   if_idx, d_idx;

    assign if_idx = if_addr[ADDR_WIDTH+1:2];
    assign d_idx  = d_addr[ADDR_WIDTH+1:2];

    // Byte offset and high address bits carry no meaning for a word memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                                d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = d_be[gi] ? d_wdata[gi*8 +: 8]
                                                     : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    // Outputs are gated by rst_n so they drop to zero as soon as reset asserts.
    always_comb begin
        state_next = state_reg;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rmw_load   = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    if (if_req && (!d_req || starve_cnt_reg == STARVE_MAX)) begin
                        if_gnt   = 1'b1;
                        mem_addr = if_idx;
                    end else if (d_req) begin
                        d_gnt    = 1'b1;
                        mem_addr = d_idx;
                        if (d_we) begin
                            if (d_be == BE_ALL) begin
                                mem_we    = 1'b1;
                                mem_wdata = d_wdata;
                            end else if (d_be != '0) begin
                                rmw_load   = 1'b1;
                                state_next = RMW_WR;
                            end
                        end
                    end
                end
                RMW_WR: begin
                    mem_we     = 1'b1;
                    mem_addr   = rmw_addr_reg;
                    mem_wdata  = rmw_data_reg;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req || if_gnt)
            starve_cnt_next = 4'd0;
        else if (starve_cnt_reg < STARVE_MAX)
            starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
            rmw_addr_reg   <= '0;
            rmw_data_reg   <= '0;
            if_rvalid_reg  <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            if_rvalid_reg  <= if_gnt;
            d_rvalid_reg   <= d_gnt && !d_we;
            if (if_gnt)
                if_rdata_reg <= mem_rdata;
            if (d_gnt && !d_we)
                d_rdata_reg <= mem_rdata;
            if (rmw_load) begin
                rmw_addr_reg <= d_idx;
                rmw_data_reg <= merged_word;
            end
        end
    end

    assign if_rvalid = if_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rvalid  = d_rvalid_reg;
    assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory attached.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];
    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .FETCH_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    always @(negedge clk)
        if (rst_n && (if_gnt || d_gnt || mem_we))
            $display("txn t=%0t if_gnt=%b d_gnt=%b we=%b addr=%0d wdata=%h rdata=%h",
                     $time, if_gnt, d_gnt, mem_we, mem_addr, mem_wdata, mem_rdata);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        if_req = 1; if_addr = 32'h0;
        tick();
        #2 rst_n = 0;
        #1;
        n_vec++; if (if_gnt !== 1'b0) begin n_err++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
        n_vec++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin n_err++; $display("FAIL rst_if_rd: got %b/%h want 0/0", if_rvalid, if_rdata); end
        n_vec++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem: got %b/%0d/%h want 0/0/0", mem_we, mem_addr, mem_wdata); end
        n_vec++; if (d_gnt !== 1'b0 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_d: got %b/%b/%h want 0/0/0", d_gnt, d_rvalid, d_rdata); end
        idle_inputs();
        tick();
        rst_n = 1;
        tick();
        if_req = 1; if_addr = 32'h0;
        #1;
        n_vec++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL first_fetch_gnt: got %b want 1", if_gnt); end
        tick();
        if_req = 0;
        n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h003100b3) begin n_err++; $display("FAIL first_fetch_data: got %b/%h want 1/003100b3", if_rvalid, if_rdata); end
        tick();
        n_vec++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL first_fetch_rvalid_len: got %b want 0", if_rvalid); end
    endtask

    task automatic test_full_store();
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        #1;
        n_vec++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd4 || mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL full_store: got gnt=%b we=%b addr=%0d wd=%h want 1/1/4/deadbeef", d_gnt, mem_we, mem_addr, mem_wdata); end
        tick();
        d_we = 0; d_be = 0;
        #1;
        n_vec++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL load_gnt: got gnt=%b we=%b want 1/0", d_gnt, mem_we); end
        n_vec++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL store_no_rvalid: got %b want 0", d_rvalid); end
        tick();
        d_req = 0;
        n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_after_store: got %b/%h want 1/deadbeef", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_partial_store();
        mem[4] = 32'h11223344;
        d_req = 1; d_we = 1; d_be = 4'b0010; d_addr = 32'h10; d_wdata = 32'h0000AA00;
        #1;
        n_vec++; if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd4) begin n_err++; $display("FAIL rmw_read: got gnt=%b we=%b addr=%0d want 1/0/4", d_gnt, mem_we, mem_addr); end
        tick();
        d_we = 0; d_be = 0;
        #1;
        n_vec++; if (d_gnt !== 1'b0 || if_gnt !== 1'b0) begin n_err++; $display("FAIL rmw_no_gnt: got d=%b if=%b want 0/0", d_gnt, if_gnt); end
        n_vec++; if (mem_we !== 1'b1 || mem_addr !== 10'd4 || mem_wdata !== 32'h1122AA44) begin n_err++; $display("FAIL rmw_write: got %b/%0d/%h want 1/4/1122aa44", mem_we, mem_addr, mem_wdata); end
        tick();
        n_vec++; if (mem[4] !== 32'h1122AA44) begin n_err++; $display("FAIL rmw_mem: got %h want 1122aa44", mem[4]); end
        n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL stalled_load_gnt: got %b want 1", d_gnt); end
        tick();
        d_req = 0;
        n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122AA44) begin n_err++; $display("FAIL stalled_load_data: got %b/%h want 1/1122aa44", d_rvalid, d_rdata); end
        d_req = 1; d_we = 1; d_be = 4'h0; d_addr = 32'h10; d_wdata = 32'hFFFFFFFF;
        #1;
        n_vec++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL be0_store: got gnt=%b we=%b want 1/0", d_gnt, mem_we); end
        tick();
        idle_inputs();
        #1;
        n_vec++; if (mem_we !== 1'b0 || mem[4] !== 32'h1122AA44) begin n_err++; $display("FAIL be0_nowrite: got we=%b mem=%h want 0/1122aa44", mem_we, mem[4]); end
        tick();
    endtask

    task automatic test_starvation();
        if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL starve_data_%0d: got d=%b if=%b want 1/0", i, d_gnt, if_gnt); end
            tick();
        end
        #1;
        n_vec++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_err++; $display("FAIL starve_fetch: got if=%b d=%b want 1/0", if_gnt, d_gnt); end
        tick();
        #1;
        n_vec++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL starve_cleared: got d=%b if=%b want 1/0", d_gnt, if_gnt); end
        n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00000013) begin n_err++; $display("FAIL starve_fetch_data: got %b/%h want 1/00000013", if_rvalid, if_rdata); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_fetch_during_rmw();
        mem[8] = 32'hA5A5A5A5;
        if_req = 1; if_addr = 32'h0;
        d_req = 1; d_we = 1; d_be = 4'b0001; d_addr = 32'h20; d_wdata = 32'h000000EE;
        #1;
        n_vec++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL rmwf_store: got d=%b if=%b want 1/0", d_gnt, if_gnt); end
        tick();
        d_req = 0;
        #1;
        n_vec++; if (if_gnt !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'hA5A5A5EE) begin n_err++; $display("FAIL rmwf_wr: got if=%b we=%b wd=%h want 0/1/a5a5a5ee", if_gnt, mem_we, mem_wdata); end
        tick();
        n_vec++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL rmwf_fetch_after: got %b want 1", if_gnt); end
        tick();
        if_req = 0;
        tick();
        // Continuous loads after the RMW: the RMW_WR cycle must count toward starvation.
        if_req = 1;
        d_req = 1; d_we = 1; d_be = 4'b1000; d_addr = 32'h20; d_wdata = 32'h77000000;
        tick();
        d_we = 0; d_be = 0;
        #1;
        n_vec++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_err++; $display("FAIL rmwc_wr: got if=%b d=%b want 0/0", if_gnt, d_gnt); end
        tick();
        n_vec++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL rmwc_load1: got d=%b if=%b want 1/0", d_gnt, if_gnt); end
        tick();
        n_vec++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL rmwc_load2: got d=%b if=%b want 1/0", d_gnt, if_gnt); end
        n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h77A5A5EE) begin n_err++; $display("FAIL rmwc_data: got %b/%h want 1/77a5a5ee", d_rvalid, d_rdata); end
        tick();
        n_vec++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_err++; $display("FAIL rmwc_fetch: got if=%b d=%b want 1/0", if_gnt, d_gnt); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_in_rmw();
        mem[7] = 32'hCAFEF00D;
        d_req = 1; d_we = 1; d_be = 4'b0100; d_addr = 32'h1C; d_wdata = 32'h00330000;
        tick();
        d_req = 0; d_we = 0; d_be = 0;
        n_vec++; if (mem_we !== 1'b1 || mem_addr !== 10'd7) begin n_err++; $display("FAIL rstrmw_pre: got we=%b addr=%0d want 1/7", mem_we, mem_addr); end
        rst_n = 0;
        #1;
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rstrmw_we_drop: got %b want 0", mem_we); end
        @(posedge clk);
        #3 rst_n = 1;
        n_vec++; if (mem[7] !== 32'hCAFEF00D) begin n_err++; $display("FAIL rstrmw_mem: got %h want cafef00d", mem[7]); end
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h1C;
        #1;
        n_vec++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL rstrmw_idle: got gnt=%b we=%b want 1/0", d_gnt, mem_we); end
        tick();
        d_req = 0;
        n_vec++; if (d_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL rstrmw_load: got %h want cafef00d", d_rdata); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h003100b3;
        mem[1] = 32'h00000013;
        idle_inputs();
        rst_n = 0;
        #1;
        n_vec++; if (if_gnt !== 1'b0 || mem_we !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_err++; $display("FAIL init_reset: got %b%b%b%b want 0000", if_gnt, mem_we, if_rvalid, d_rvalid); end
        tick();
        tick();
        rst_n = 1;
        tick();
        test_reset();
        test_full_store();
        test_partial_store();
        test_starvation();
        test_fetch_during_rmw();
        test_reset_in_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
